fpu_issue_ctrl: RTL and testbench

Initiator-side controller for the FPU handshake: accepts floating-point operation requests from a core-side stream, registers them onto the FPU request port, and assigns each a unique tag. It collects tagged FPU results in a reorder buffer and returns them to the core strictly in issue order. It sits between a Composer core's datapath and the FPNew blackbox.

---
 rtl/fpu_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// Issue/reorder controller between a core request stream and the FPNew unit.
// Tags each issued op with its reorder slot and returns results in issue order.
module fpu_issue_ctrl #(
    parameter int unsigned FLEN      = 16,
    parameter int unsigned TAG_WIDTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [3*FLEN-1:0]      req_operands_i,
    input  logic [3:0]             req_op_i,
    input  logic                   req_op_mod_i,
    input  logic [2:0]             req_rnd_mode_i,
    input  logic [2:0]             req_fmt_i,
    input  logic                   req_vec_i,
    output logic                   fpu_in_valid_o,
    input  logic                   fpu_in_ready_i,
    output logic [3*FLEN-1:0]      fpu_operands_o,
    output logic [3:0]             fpu_op_o,
    output logic                   fpu_op_mod_o,
    output logic [2:0]             fpu_rnd_mode_o,
    output logic [2:0]             fpu_src_fmt_o,
    output logic [2:0]             fpu_dst_fmt_o,
    output logic                   fpu_vec_o,
    output logic [TAG_WIDTH-1:0]   fpu_tag_o,
    input  logic                   fpu_out_valid_i,
    output logic                   fpu_out_ready_o,
    input  logic [FLEN-1:0]        fpu_result_i,
    input  logic [4:0]             fpu_status_i,
    input  logic [TAG_WIDTH-1:0]   fpu_tag_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [FLEN-1:0]        rsp_result_o,
    output logic [4:0]             rsp_status_o,
    output logic [TAG_WIDTH:0]     inflight_o,
    output logic                   busy_o,
    output logic                   error_o
);

    localparam int unsigned N = 1 << TAG_WIDTH;

    logic                 r_in_valid;
    logic [3*FLEN-1:0]    r_ops;
    logic [3:0]           r_op;
    logic                 r_op_mod;
    logic [2:0]           r_rnd;
    logic [2:0]           r_fmt;
    logic                 r_vec;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [TAG_WIDTH-1:0] r_ip;
    logic [TAG_WIDTH-1:0] r_hp;
    logic [N-1:0]         r_alloc;
    logic [N-1:0]         r_done;
    logic [FLEN-1:0]      r_res  [N];
    logic [4:0]           r_stat [N];
    logic [TAG_WIDTH:0]   r_inflight;
    logic                 r_error;

    logic w_req_ready;
    logic w_req_fire;
    logic w_rsp_valid;
    logic w_rsp_fire;
    logic w_cap_ok;

    // Accept only into a free slot; alloc is registered so retire of the same slot waits a cycle.
    assign w_req_ready = (!r_in_valid || fpu_in_ready_i) && !r_alloc[r_ip];
    assign w_req_fire  = req_valid_i && w_req_ready;
    assign w_rsp_valid = r_done[r_hp];
    assign w_rsp_fire  = w_rsp_valid && rsp_ready_i;
    assign w_cap_ok    = fpu_out_valid_i && r_alloc[fpu_tag_i] && !r_done[fpu_tag_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_in_valid <= 1'b0;
            r_ops      <= '0;
            r_op       <= '0;
            r_op_mod   <= 1'b0;
            r_rnd      <= '0;
            r_fmt      <= '0;
            r_vec      <= 1'b0;
            r_tag      <= '0;
        end else if (w_req_fire) begin
            r_in_valid <= 1'b1;
            r_ops      <= req_operands_i;
            r_op       <= req_op_i;
            r_op_mod   <= req_op_mod_i;
            r_rnd      <= req_rnd_mode_i;
            r_fmt      <= req_fmt_i;
            r_vec      <= req_vec_i;
            r_tag      <= r_ip;
        end else if (fpu_in_ready_i) begin
            r_in_valid <= 1'b0;
        end
    end

    // Slot bookkeeping: accept, capture and retire always touch distinct slots.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ip       <= '0;
            r_hp       <= '0;
            r_alloc    <= '0;
            r_done     <= '0;
            r_inflight <= '0;
            r_error    <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_alloc[r_ip] <= 1'b1;
                r_ip          <= r_ip + TAG_WIDTH'(1);
            end
            if (w_rsp_fire) begin
                r_alloc[r_hp] <= 1'b0;
                r_done[r_hp]  <= 1'b0;
                r_hp          <= r_hp + TAG_WIDTH'(1);
            end
            if (w_cap_ok) begin
                r_done[fpu_tag_i] <= 1'b1;
            end
            if (fpu_out_valid_i && !w_cap_ok) begin
                r_error <= 1'b1;
            end
            case ({w_req_fire, w_rsp_fire})
                2'b10:   r_inflight <= r_inflight + (TAG_WIDTH+1)'(1);
                2'b01:   r_inflight <= r_inflight - (TAG_WIDTH+1)'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_res[i]  <= '0;
                r_stat[i] <= '0;
            end
        end else if (w_cap_ok) begin
            r_res[fpu_tag_i]  <= fpu_result_i;
            r_stat[fpu_tag_i] <= fpu_status_i;
        end
    end

    assign req_ready_o     = w_req_ready;
    assign fpu_in_valid_o  = r_in_valid;
    assign fpu_operands_o  = r_ops;
    assign fpu_op_o        = r_op;
    assign fpu_op_mod_o    = r_op_mod;
    assign fpu_rnd_mode_o  = r_rnd;
    assign fpu_src_fmt_o   = r_fmt;
    assign fpu_dst_fmt_o   = r_fmt;
    assign fpu_vec_o       = r_vec;
    assign fpu_tag_o       = r_tag;
    assign fpu_out_ready_o = 1'b1;
    assign rsp_valid_o     = w_rsp_valid;
    assign rsp_result_o    = r_res[r_hp];
    assign rsp_status_o    = r_stat[r_hp];
    assign inflight_o      = r_inflight;
    assign busy_o          = (r_inflight != '0) || r_in_valid;
    assign error_o         = r_error;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: random core traffic, an out-of-order FPU model
// and an in-order response monitor, plus directed latency/full/stall/error/reset cases.
module tb_fpu_issue_ctrl;

    localparam int unsigned FLEN = 16;
    localparam int unsigned TW   = 2;
    localparam int unsigned N    = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [3*FLEN-1:0] req_operands_i;
    logic [3:0]        req_op_i;
    logic              req_op_mod_i;
    logic [2:0]        req_rnd_mode_i;
    logic [2:0]        req_fmt_i;
    logic              req_vec_i;
    logic              fpu_in_valid_o;
    logic              fpu_in_ready_i;
    logic [3*FLEN-1:0] fpu_operands_o;
    logic [3:0]        fpu_op_o;
    logic              fpu_op_mod_o;
    logic [2:0]        fpu_rnd_mode_o;
    logic [2:0]        fpu_src_fmt_o;
    logic [2:0]        fpu_dst_fmt_o;
    logic              fpu_vec_o;
    logic [TW-1:0]     fpu_tag_o;
    logic              fpu_out_valid_i;
    logic              fpu_out_ready_o;
    logic [FLEN-1:0]   fpu_result_i;
    logic [4:0]        fpu_status_i;
    logic [TW-1:0]     fpu_tag_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [FLEN-1:0]   rsp_result_o;
    logic [4:0]        rsp_status_o;
    logic [TW:0]       inflight_o;
    logic              busy_o;
    logic              error_o;

    fpu_issue_ctrl #(.FLEN(FLEN), .TAG_WIDTH(TW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_operands_i(req_operands_i), .req_op_i(req_op_i), .req_op_mod_i(req_op_mod_i),
        .req_rnd_mode_i(req_rnd_mode_i), .req_fmt_i(req_fmt_i), .req_vec_i(req_vec_i),
        .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_op_mod_o(fpu_op_mod_o),
        .fpu_rnd_mode_o(fpu_rnd_mode_o), .fpu_src_fmt_o(fpu_src_fmt_o),
        .fpu_dst_fmt_o(fpu_dst_fmt_o), .fpu_vec_o(fpu_vec_o), .fpu_tag_o(fpu_tag_o),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
        .inflight_o(inflight_o), .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [FLEN-1:0] res;
        logic [4:0]      st;
    } exp_t;

    typedef struct {
        int            due;
        logic [TW-1:0] tag;
        exp_t          r;
    } pend_t;

    exp_t  sb[$];
    pend_t pend[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    n_fired = 0;
    int    n_target = 0;
    int    p_req = 100;
    int    p_in_rdy = 100;
    int    p_rsp_rdy = 100;
    int    lat_min = 1;
    int    lat_max = 1;
    bit    inj = 1'b0;
    bit    chk_en = 1'b0;
    logic [TW-1:0] inj_tag = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference FPU behaviour: arbitrary arithmetic mixing every request field.
    function automatic exp_t ref_fn(input logic [3*FLEN-1:0] ops, input logic [3:0] op,
                                    input logic md, input logic [2:0] rnd,
                                    input logic [2:0] sfmt, input logic [2:0] dfmt,
                                    input logic vec);
        exp_t e;
        int   s;
        s = int'(ops[FLEN-1:0]) + 3 * int'(ops[2*FLEN-1:FLEN]) - int'(ops[3*FLEN-1:2*FLEN])
            + 7 * int'(op) + 11 * int'(rnd) + 13 * int'(sfmt) + 17 * int'(md) + 19 * int'(vec);
        e.res = FLEN'(s);
        e.st  = 5'(op) ^ 5'({rnd, md}) ^ {dfmt, vec, md};
        return e;
    endfunction

    // Core-side driver: the expected response is queued at the moment of acceptance.
    initial begin
        bit fired;
        req_valid_i = 1'b0; req_operands_i = '0; req_op_i = '0; req_op_mod_i = 1'b0;
        req_rnd_mode_i = '0; req_fmt_i = '0; req_vec_i = 1'b0;
        forever begin
            @(negedge clk_i);
            fired = 1'b0;
            if (!rst_i && req_valid_i && req_ready_o) begin
                sb.push_back(ref_fn(req_operands_i, req_op_i, req_op_mod_i, req_rnd_mode_i,
                                    req_fmt_i, req_fmt_i, req_vec_i));
                n_fired++;
                fired = 1'b1;
            end
            @(posedge clk_i); #1;
            if (rst_i) begin
                req_valid_i = 1'b0;
            end else if (fired || !req_valid_i) begin
                if (n_fired < n_target && $urandom_range(99) < 32'(p_req)) begin
                    req_operands_i = 48'({$urandom(), $urandom()});
                    req_op_i       = 4'($urandom());
                    req_op_mod_i   = 1'($urandom());
                    req_rnd_mode_i = 3'($urandom());
                    req_fmt_i      = 3'($urandom());
                    req_vec_i      = 1'($urandom());
                    req_valid_i    = 1'b1;
                end else begin
                    req_valid_i = 1'b0;
                end
            end
        end
    end

    // FPU model: random latency, results returned in random order among ready ones.
    initial begin
        logic [TW-1:0] nxt_tag;
        int            idx[$];
        int            j;
        nxt_tag = '0;
        fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0;
        fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                pend.delete();
                nxt_tag = '0;
            end else if (fpu_in_valid_o && fpu_in_ready_i) begin
                chk("fpu_tag", 64'(fpu_tag_o), 64'(nxt_tag));
                nxt_tag++;
                pend.push_back('{cyc + int'($urandom_range(32'(lat_max), 32'(lat_min))), fpu_tag_o,
                                 ref_fn(fpu_operands_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o,
                                        fpu_src_fmt_o, fpu_dst_fmt_o, fpu_vec_o)});
            end
            @(posedge clk_i); #1;
            fpu_out_valid_i = 1'b0;
            fpu_in_ready_i  = 1'b0;
            if (!rst_i) begin
                if (inj) begin
                    fpu_out_valid_i = 1'b1;
                    fpu_tag_i       = inj_tag;
                    fpu_result_i    = 16'hdead;
                    fpu_status_i    = 5'h1f;
                end else begin
                    idx.delete();
                    foreach (pend[k]) if (pend[k].due <= cyc) idx.push_back(k);
                    if (idx.size() > 0) begin
                        j = idx[$urandom_range(32'(idx.size() - 1))];
                        fpu_out_valid_i = 1'b1;
                        fpu_tag_i       = pend[j].tag;
                        fpu_result_i    = pend[j].r.res;
                        fpu_status_i    = pend[j].r.st;
                        pend.delete(j);
                    end
                end
                fpu_in_ready_i = ($urandom_range(99) < 32'(p_in_rdy));
            end
        end
    end

    // Response monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t        e;
        bit          hold;
        logic [21:0] held;
        hold = 1'b0; held = '0;
        rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (hold) chk("rsp_stable", 64'({rsp_valid_o, rsp_result_o, rsp_status_o}), 64'(held));
                if (rsp_valid_o && rsp_ready_i) begin
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL rsp_unexpected: got result %0h with nothing outstanding", rsp_result_o);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_result", 64'(rsp_result_o), 64'(e.res));
                        chk("rsp_status", 64'(rsp_status_o), 64'(e.st));
                    end
                end
                hold = rsp_valid_o && !rsp_ready_i;
                held = {rsp_valid_o, rsp_result_o, rsp_status_o};
            end else begin
                hold = 1'b0;
            end
            @(posedge clk_i); #1;
            rsp_ready_i = !rst_i && ($urandom_range(99) < 32'(p_rsp_rdy));
        end
    end

    // Occupancy checks against the count of accepted-but-unretired requests.
    initial forever begin
        @(posedge clk_i); #2;
        if (chk_en && !rst_i) begin
            chk("inflight", 64'(inflight_o), 64'(sb.size()));
            chk("busy", 64'(busy_o), 64'(sb.size() != 0));
            if (sb.size() == N) chk("full_ready", 64'(req_ready_o), 64'(0));
        end
    end

    task automatic drain();
        int k;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk_i);
            if (n_fired == n_target && sb.size() == 0) break;
        end
        chk("drain_done", 64'(k < 5000), 64'(1));
        repeat (2) @(negedge clk_i);
        chk("idle_inflight", 64'(inflight_o), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'(1));
        chk({tag, "_in_valid"}, 64'(fpu_in_valid_o), 64'(0));
        chk({tag, "_tag"}, 64'(fpu_tag_o), 64'(0));
        chk({tag, "_fields"}, 64'({fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o, fpu_src_fmt_o,
                                   fpu_dst_fmt_o, fpu_vec_o}), 64'(0));
        chk({tag, "_operands"}, 64'(fpu_operands_o), 64'(0));
        chk({tag, "_out_ready"}, 64'(fpu_out_ready_o), 64'(1));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(0));
        chk({tag, "_rsp_data"}, 64'({rsp_result_o, rsp_status_o}), 64'(0));
        chk({tag, "_inflight"}, 64'(inflight_o), 64'(0));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_error"}, 64'(error_o), 64'(0));
    endtask

    initial begin
        int         k;
        logic [47:0] s_ops;
        logic [16:0] s_fld;
        rst_i = 1'b1;
        #1;
        check_reset_values("rst");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i  = 1'b0;
        chk_en = 1'b1;

        // single op, FPU latency 1, always-ready response side
        n_target = 1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (req_valid_i && req_ready_o) break;
        end
        for (k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            if (rsp_valid_o) break;
        end
        chk("single_latency", 64'(k), 64'(3));
        drain();

        // fill all slots with responses blocked
        p_rsp_rdy = 0;
        n_target += 5;
        repeat (15) @(negedge clk_i);
        chk("fill_inflight", 64'(inflight_o), 64'(4));
        chk("fill_req_ready", 64'(req_ready_o), 64'(0));
        chk("fill_accepted", 64'(n_fired), 64'(n_target - 1));
        p_rsp_rdy = 100;
        drain();

        // FPU stalls: issued request and its fields must hold
        p_in_rdy = 0;
        n_target += 2;
        repeat (6) @(negedge clk_i);
        chk("stall_valid", 64'(fpu_in_valid_o), 64'(1));
        s_ops = fpu_operands_o;
        s_fld = {fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_vec_o, fpu_tag_o};
        repeat (3) @(negedge clk_i);
        chk("stall_valid_held", 64'(fpu_in_valid_o), 64'(1));
        chk("stall_ops_held", 64'(fpu_operands_o), 64'(s_ops));
        chk("stall_fields_held", 64'({fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o, fpu_src_fmt_o,
                                      fpu_dst_fmt_o, fpu_vec_o, fpu_tag_o}), 64'(s_fld));
        chk("stall_req_ready", 64'(req_ready_o), 64'(0));
        p_in_rdy = 100;
        drain();

        // random traffic with out-of-order completion
        p_req = 70; p_in_rdy = 60; p_rsp_rdy = 60; lat_min = 1; lat_max = 6;
        n_target += 300;
        drain();

        // stray result for an unallocated tag
        chk("err_before", 64'(error_o), 64'(0));
        @(negedge clk_i);
        inj_tag = 2'($urandom());
        inj = 1'b1;
        @(negedge clk_i);
        inj = 1'b0;
        @(negedge clk_i);
        chk("err_set", 64'(error_o), 64'(1));
        chk("err_inflight", 64'(inflight_o), 64'(0));
        chk("err_rsp_valid", 64'(rsp_valid_o), 64'(0));
        n_target += 40;
        drain();
        chk("err_sticky", 64'(error_o), 64'(1));

        // asynchronous reset with ops in flight
        p_req = 100; p_in_rdy = 100; p_rsp_rdy = 0; lat_min = 1; lat_max = 3;
        n_target += 3;
        for (k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (sb.size() == 3) break;
        end
        chk("pre_reset_inflight", 64'(inflight_o), 64'(3));
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        sb.delete();
        n_target = n_fired;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        p_rsp_rdy = 100; lat_max = 1;
        n_target += 1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (fpu_in_valid_o) break;
        end
        chk("post_reset_valid", 64'(fpu_in_valid_o), 64'(1));
        chk("post_reset_tag", 64'(fpu_tag_o), 64'(0));
        drain();
        p_req = 80; p_in_rdy = 70; p_rsp_rdy = 70; lat_max = 4;
        n_target += 40;
        drain();
        chk("final_error", 64'(error_o), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
